// File: rtl/panda_risc_v_dpc_pkg.sv
// rtl/panda_risc_v_dpc_pkg.sv - shared constants for the data-dependency tracker
// Purpose: slot-state encodings, default instruction-ID width and the x0 register index.
// Ports: none (package).
package panda_risc_v_dpc_pkg;

  typedef logic [1:0] dpc_state_t;

  localparam dpc_state_t DPC_ST_IDLE  = 2'b00;
  localparam dpc_state_t DPC_ST_DCD   = 2'b01;
  localparam dpc_state_t DPC_ST_DSPTC = 2'b10;

  localparam int unsigned DPC_INST_ID_W = 4;

  localparam logic [4:0] REG_ZERO_ID = 5'd0;

endpackage

// File: rtl/panda_risc_v_dpc_slot.sv
// rtl/panda_risc_v_dpc_slot.sv - per-instruction-ID slot state machine and fields
// Purpose: tracks one instruction ID through IDLE -> DCD -> DSPTC -> IDLE and holds its RD info.
// Ports:
//   clk, sys_resetn        clock, asynchronous active-low reset
//   flush_i                pipeline flush (DCD slot returns to IDLE)
//   dcd_hit_i              decode event addressed to this slot, with rd/rd_vld/is_long fields
//   dsptc_hit_i            dispatch event addressed to this slot
//   retire_hit_i           retire event addressed to this slot
//   rd_id_o/rd_vld_o/is_long_o  captured RD information
//   in_dsptc_o             slot is in DSPTC
//   dsptc_ok_o/retire_ok_o accepted dispatch / retire this cycle
//   err_o                  an event addressed to this slot is illegal this cycle
module panda_risc_v_dpc_slot
  import panda_risc_v_dpc_pkg::*;
(
  input  logic       clk,
  input  logic       sys_resetn,
  input  logic       flush_i,
  input  logic       dcd_hit_i,
  input  logic [4:0] dcd_rd_id_i,
  input  logic       dcd_rd_vld_i,
  input  logic       dcd_is_long_i,
  input  logic       dsptc_hit_i,
  input  logic       retire_hit_i,
  output logic [4:0] rd_id_o,
  output logic       rd_vld_o,
  output logic       is_long_o,
  output logic       in_dsptc_o,
  output logic       dsptc_ok_o,
  output logic       retire_ok_o,
  output logic       err_o
);

  dpc_state_t state_q, state_d;
  logic [4:0] rd_id_q;
  logic       rd_vld_q;
  logic       is_long_q;

  logic retire_ok;
  logic dsptc_ok;
  logic dcd_ok;
  logic idle_after_retire;

  // Events are qualified against the registered state. The retire is applied
  // ahead of a same-cycle decode so a retiring slot can be reused at once.
  // Decode/dispatch coinciding with a flush are dropped silently.
  assign retire_ok         = retire_hit_i & (state_q == DPC_ST_DSPTC);
  assign dsptc_ok          = dsptc_hit_i & ~flush_i & (state_q == DPC_ST_DCD);
  assign idle_after_retire = (state_q == DPC_ST_IDLE) | retire_ok;
  assign dcd_ok            = dcd_hit_i & ~flush_i & idle_after_retire;

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q <= DPC_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DPC_ST_IDLE: begin
        if (dcd_ok) state_d = DPC_ST_DCD;
      end
      DPC_ST_DCD: begin
        if (dsptc_ok)     state_d = DPC_ST_DSPTC;
        else if (flush_i) state_d = DPC_ST_IDLE;
      end
      DPC_ST_DSPTC: begin
        if (dcd_ok)         state_d = DPC_ST_DCD;
        else if (retire_ok) state_d = DPC_ST_IDLE;
      end
      default: state_d = DPC_ST_IDLE;
    endcase
  end

  always_comb begin
    in_dsptc_o  = (state_q == DPC_ST_DSPTC);
    dsptc_ok_o  = dsptc_ok;
    retire_ok_o = retire_ok;
    err_o       = (dcd_hit_i & ~flush_i & ~idle_after_retire)
                | (dsptc_hit_i & ~flush_i & (state_q != DPC_ST_DCD))
                | (retire_hit_i & ~retire_ok);
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rd_id_q   <= REG_ZERO_ID;
      rd_vld_q  <= 1'b0;
      is_long_q <= 1'b0;
    end else if (dcd_ok) begin
      rd_id_q   <= dcd_rd_id_i;
      rd_vld_q  <= dcd_rd_vld_i;
      is_long_q <= dcd_is_long_i;
    end
  end

  assign rd_id_o   = rd_id_q;
  assign rd_vld_o  = rd_vld_q;
  assign is_long_o = is_long_q;

endmodule

// File: rtl/panda_risc_v_dpc_tracker.sv
// rtl/panda_risc_v_dpc_tracker.sv - RAW/WAW data-dependency tracker for decode/dispatch
// Purpose: one slot per instruction ID; answers RS1/RS2 RAW and RD WAW checks each cycle,
//   counts dispatched-but-not-retired instructions and flags protocol errors.
// Optional feature macro: PANDA_RISC_V_DPC_RETIRE_BYPASS_EN (a retiring slot is masked
//   out of the hazard match in the same cycle).
// Ports:
//   clk, sys_resetn                     clock, asynchronous active-low reset
//   flush_req                           pipeline flush
//   dpc_trace_dcd_*                     decode event (inst_id, rd_id, rd_vld, is_long, valid)
//   dpc_trace_dsptc_*                   dispatch event (inst_id, valid)
//   dpc_trace_retire_*                  retire event (inst_id, valid)
//   raw_dpc_check_rs1_id / rs1_raw_dpc  RS1 RAW check
//   raw_dpc_check_rs2_id / rs2_raw_dpc  RS2 RAW check
//   waw_dpc_check_rd_id / rd_waw_dpc    RD WAW check against outstanding long instructions
//   dpc_outstanding_n                   number of slots in DSPTC
//   dpc_tracker_err                     sticky protocol-error flag
module panda_risc_v_dpc_tracker
  import panda_risc_v_dpc_pkg::*;
#(
  parameter int simulation_delay = 1,
  parameter int INST_ID_W        = DPC_INST_ID_W
) (
  input  logic                 clk,
  input  logic                 sys_resetn,
  input  logic                 flush_req,
  input  logic [INST_ID_W-1:0] dpc_trace_dcd_inst_id,
  input  logic [4:0]           dpc_trace_dcd_rd_id,
  input  logic                 dpc_trace_dcd_rd_vld,
  input  logic                 dpc_trace_dcd_is_long,
  input  logic                 dpc_trace_dcd_valid,
  input  logic [INST_ID_W-1:0] dpc_trace_dsptc_inst_id,
  input  logic                 dpc_trace_dsptc_valid,
  input  logic [INST_ID_W-1:0] dpc_trace_retire_inst_id,
  input  logic                 dpc_trace_retire_valid,
  input  logic [4:0]           raw_dpc_check_rs1_id,
  output logic                 rs1_raw_dpc,
  input  logic [4:0]           raw_dpc_check_rs2_id,
  output logic                 rs2_raw_dpc,
  input  logic [4:0]           waw_dpc_check_rd_id,
  output logic                 rd_waw_dpc,
  output logic [INST_ID_W:0]   dpc_outstanding_n,
  output logic                 dpc_tracker_err
);

  localparam int DEPTH = 1 << INST_ID_W;
  localparam int CNT_W = INST_ID_W + 1;

  // simulation_delay only shapes simulation-side NBA timing; the synthesizable
  // body has no delays, so it is merely tied off here.
  logic unused_sim_delay;
  assign unused_sim_delay = (simulation_delay != 0);

  logic [4:0]       slot_rd_id [DEPTH];
  logic [DEPTH-1:0] slot_rd_vld, slot_is_long, in_dsptc;
  logic [DEPTH-1:0] dsptc_ok, retire_ok, slot_err, live;
  logic [DEPTH-1:0] rs1_hit, rs2_hit, rd_hit;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    panda_risc_v_dpc_slot u_slot (
      .clk          (clk),
      .sys_resetn   (sys_resetn),
      .flush_i      (flush_req),
      .dcd_hit_i    (dpc_trace_dcd_valid & (dpc_trace_dcd_inst_id == INST_ID_W'(i))),
      .dcd_rd_id_i  (dpc_trace_dcd_rd_id),
      .dcd_rd_vld_i (dpc_trace_dcd_rd_vld),
      .dcd_is_long_i(dpc_trace_dcd_is_long),
      .dsptc_hit_i  (dpc_trace_dsptc_valid & (dpc_trace_dsptc_inst_id == INST_ID_W'(i))),
      .retire_hit_i (dpc_trace_retire_valid & (dpc_trace_retire_inst_id == INST_ID_W'(i))),
      .rd_id_o      (slot_rd_id[i]),
      .rd_vld_o     (slot_rd_vld[i]),
      .is_long_o    (slot_is_long[i]),
      .in_dsptc_o   (in_dsptc[i]),
      .dsptc_ok_o   (dsptc_ok[i]),
      .retire_ok_o  (retire_ok[i]),
      .err_o        (slot_err[i])
    );

`ifdef PANDA_RISC_V_DPC_RETIRE_BYPASS_EN
    assign live[i] = in_dsptc[i] & slot_rd_vld[i] & ~retire_ok[i];
`else
    assign live[i] = in_dsptc[i] & slot_rd_vld[i];
`endif

    assign rs1_hit[i] = live[i] & (slot_rd_id[i] == raw_dpc_check_rs1_id);
    assign rs2_hit[i] = live[i] & (slot_rd_id[i] == raw_dpc_check_rs2_id);
    assign rd_hit[i]  = live[i] & slot_is_long[i] & (slot_rd_id[i] == waw_dpc_check_rd_id);
  end

  assign rs1_raw_dpc = (raw_dpc_check_rs1_id != REG_ZERO_ID) & (|rs1_hit);
  assign rs2_raw_dpc = (raw_dpc_check_rs2_id != REG_ZERO_ID) & (|rs2_hit);
  assign rd_waw_dpc  = (waw_dpc_check_rd_id != REG_ZERO_ID) & (|rd_hit);

  // At most one dispatch and one retire are accepted per cycle, so the count
  // moves by -1..+1 and stays within 0..DEPTH.
  assign cnt_d = cnt_q + CNT_W'(|dsptc_ok) - CNT_W'(|retire_ok);
  assign err_d = err_q | (|slot_err);

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dpc_outstanding_n = cnt_q;
  assign dpc_tracker_err   = err_q;

endmodule

// File: tb/tb_panda_risc_v_dpc_tracker.sv
// tb/tb_panda_risc_v_dpc_tracker.sv - self-checking bench for panda_risc_v_dpc_tracker
module tb_panda_risc_v_dpc_tracker;

  localparam int N        = 16;
  localparam int S_IDLE   = 0;
  localparam int S_DCD    = 1;
  localparam int S_DSPTC  = 2;

  logic       clk = 1'b0;
  logic       sys_resetn;
  logic       flush_req;
  logic [3:0] dcd_id;
  logic [4:0] dcd_rd;
  logic       dcd_rd_vld, dcd_long, dcd_valid;
  logic [3:0] dsp_id;
  logic       dsp_valid;
  logic [3:0] ret_id;
  logic       ret_valid;
  logic [4:0] rs1, rs2, rdc;
  logic       rs1_raw_dpc, rs2_raw_dpc, rd_waw_dpc;
  logic [4:0] dpc_outstanding_n;
  logic       dpc_tracker_err;

  always #5 clk = ~clk;

  panda_risc_v_dpc_tracker dut (
    .clk                     (clk),
    .sys_resetn              (sys_resetn),
    .flush_req               (flush_req),
    .dpc_trace_dcd_inst_id   (dcd_id),
    .dpc_trace_dcd_rd_id     (dcd_rd),
    .dpc_trace_dcd_rd_vld    (dcd_rd_vld),
    .dpc_trace_dcd_is_long   (dcd_long),
    .dpc_trace_dcd_valid     (dcd_valid),
    .dpc_trace_dsptc_inst_id (dsp_id),
    .dpc_trace_dsptc_valid   (dsp_valid),
    .dpc_trace_retire_inst_id(ret_id),
    .dpc_trace_retire_valid  (ret_valid),
    .raw_dpc_check_rs1_id    (rs1),
    .rs1_raw_dpc             (rs1_raw_dpc),
    .raw_dpc_check_rs2_id    (rs2),
    .rs2_raw_dpc             (rs2_raw_dpc),
    .waw_dpc_check_rd_id     (rdc),
    .rd_waw_dpc              (rd_waw_dpc),
    .dpc_outstanding_n       (dpc_outstanding_n),
    .dpc_tracker_err         (dpc_tracker_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-ID slot lifecycle applied event by event.
  int         m_st   [N] = '{default: 0};
  logic [4:0] m_rd   [N] = '{default: 5'd0};
  bit         m_vld  [N] = '{default: 1'b0};
  bit         m_long [N] = '{default: 1'b0};
  bit         m_err = 1'b0;
  bit         r_ok, d_ok, c_ok;
  int         eff;

  always @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = S_IDLE; m_rd[i] = 5'd0; m_vld[i] = 1'b0; m_long[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      r_ok = ret_valid && (m_st[ret_id] == S_DSPTC);
      d_ok = dsp_valid && !flush_req && (m_st[dsp_id] == S_DCD);
      eff  = (r_ok && ret_id == dcd_id) ? S_IDLE : m_st[dcd_id];
      c_ok = dcd_valid && !flush_req && (eff == S_IDLE);
      if (ret_valid && !r_ok) m_err = 1'b1;
      if (dsp_valid && !flush_req && !d_ok) m_err = 1'b1;
      if (dcd_valid && !flush_req && !c_ok) m_err = 1'b1;
      if (flush_req)
        for (int i = 0; i < N; i++) if (m_st[i] == S_DCD) m_st[i] = S_IDLE;
      if (r_ok) m_st[ret_id] = S_IDLE;
      if (d_ok) m_st[dsp_id] = S_DSPTC;
      if (c_ok) begin
        m_st[dcd_id] = S_DCD; m_rd[dcd_id] = dcd_rd;
        m_vld[dcd_id] = dcd_rd_vld; m_long[dcd_id] = dcd_long;
      end
    end
  end

  function automatic bit exp_haz(input logic [4:0] r, input bit need_long);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == S_DSPTC && m_vld[i] && m_rd[i] == r && (!need_long || m_long[i])) begin
`ifdef PANDA_RISC_V_DPC_RETIRE_BYPASS_EN
        if (!(ret_valid && ret_id == 4'(i))) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == S_DSPTC) c++;
    return c;
  endfunction

  // Every-cycle comparison against the model, midway between active edges.
  always @(negedge clk) begin
    chk("rs1_raw", rs1_raw_dpc, exp_haz(rs1, 1'b0));
    chk("rs2_raw", rs2_raw_dpc, exp_haz(rs2, 1'b0));
    chk("rd_waw", rd_waw_dpc, exp_haz(rdc, 1'b1));
    chk("outstanding", dpc_outstanding_n, exp_cnt());
    chk("err", dpc_tracker_err, m_err);
  end

  task automatic idle_in();
    dcd_valid = 1'b0; dsp_valid = 1'b0; ret_valid = 1'b0; flush_req = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1; idle_in();
  endtask

  task automatic dcd(input int id, input int rd, input bit vld, input bit lng);
    dcd_valid = 1'b1; dcd_id = 4'(id); dcd_rd = 5'(rd); dcd_rd_vld = vld; dcd_long = lng;
  endtask

  task automatic dsp(input int id);
    dsp_valid = 1'b1; dsp_id = 4'(id);
  endtask

  task automatic ret(input int id);
    ret_valid = 1'b1; ret_id = 4'(id);
  endtask

  function automatic logic [3:0] pick(input int st);
    int cand[$];
    for (int i = 0; i < N; i++) if (m_st[i] == st) cand.push_back(i);
    if (cand.size() != 0 && $urandom_range(0, 9) != 0)
      return 4'(cand[$urandom_range(0, cand.size() - 1)]);
    return 4'($urandom_range(0, N - 1));
  endfunction

  task automatic pulse_reset();
    sys_resetn = 1'b0;
    #1;
    chk("rst_rs1", rs1_raw_dpc, 0);
    chk("rst_rs2", rs2_raw_dpc, 0);
    chk("rst_waw", rd_waw_dpc, 0);
    chk("rst_cnt", dpc_outstanding_n, 0);
    chk("rst_err", dpc_tracker_err, 0);
    @(posedge clk); #1;
    sys_resetn = 1'b1;
  endtask

  initial begin
    sys_resetn = 1'b0;
    idle_in();
    dcd_id = '0; dcd_rd = '0; dcd_rd_vld = 1'b0; dcd_long = 1'b0;
    dsp_id = '0; ret_id = '0; rs1 = '0; rs2 = '0; rdc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rs1", rs1_raw_dpc, 0);
    chk("reset_cnt", dpc_outstanding_n, 0);
    chk("reset_err", dpc_tracker_err, 0);
    sys_resetn = 1'b1;

    // Hazard set and clear.
    dcd(3, 5, 1, 0); rs1 = 5'd5;
    #1 chk("dcd_no_raw", rs1_raw_dpc, 0);
    next(); dsp(3);
    #1 chk("dcd_state_excluded", rs1_raw_dpc, 0);
    next();
    #1 chk("dsptc_raw", rs1_raw_dpc, 1);
    chk("dsptc_cnt", dpc_outstanding_n, 1);
    ret(3);
`ifdef PANDA_RISC_V_DPC_RETIRE_BYPASS_EN
    #1 chk("retire_cycle_raw", rs1_raw_dpc, 0);
`else
    #1 chk("retire_cycle_raw", rs1_raw_dpc, 1);
`endif
    next();
    #1 chk("retired_raw", rs1_raw_dpc, 0);
    chk("retired_cnt", dpc_outstanding_n, 0);

    // x0 destination never creates a hazard.
    dcd(0, 0, 1, 1); next(); dsp(0); next();
    rs1 = 5'd0; rdc = 5'd0;
    #1 chk("x0_raw", rs1_raw_dpc, 0);
    chk("x0_waw", rd_waw_dpc, 0);
    chk("x0_cnt", dpc_outstanding_n, 1);
    ret(0); next();

    // WAW only against long instructions; decode and dispatch on different IDs together.
    dcd(7, 9, 1, 1); next();
    dsp(7); dcd(8, 10, 1, 0); next();
    dsp(8); next();
    rdc = 5'd9;  #1 chk("waw_long", rd_waw_dpc, 1);
    rdc = 5'd10; #1 chk("waw_short", rd_waw_dpc, 0);
    rs2 = 5'd10; #1 chk("raw_short", rs2_raw_dpc, 1);
    chk("two_cnt", dpc_outstanding_n, 2);
    ret(7); next(); ret(8); next();
    #1 chk("drain_cnt", dpc_outstanding_n, 0);
    chk("clean_err", dpc_tracker_err, 0);

    // Flush drops DCD slots, keeps DSPTC slots, discards same-cycle decode.
    dcd(2, 12, 1, 0); next();
    dsp(2); dcd(1, 13, 1, 0); next();
    flush_req = 1'b1; dcd(9, 4, 1, 0); next();
    #1 chk("flush_cnt", dpc_outstanding_n, 1);
    chk("flush_err", dpc_tracker_err, 0);
    dsp(1); next();
    #1 chk("flushed_dsp_err", dpc_tracker_err, 1);
    rs1 = 5'd12;
    #1 chk("kept_raw", rs1_raw_dpc, 1);
    pulse_reset();

    // Same-cycle retire+decode on one ID, and dispatch+retire on different IDs.
    dcd(4, 3, 1, 0); next(); dsp(4); next();
    ret(4); dcd(4, 3, 1, 1); next();
    #1 chk("reuse_err", dpc_tracker_err, 0);
    chk("reuse_cnt", dpc_outstanding_n, 0);
    dsp(4); next();
    #1 chk("reuse_dsp_cnt", dpc_outstanding_n, 1);
    chk("reuse_dsp_err", dpc_tracker_err, 0);
    dcd(5, 6, 1, 0); next(); dcd(6, 7, 1, 0); next(); dsp(6); next();
    dsp(5); ret(6); next();
    #1 chk("dsp_ret_cnt", dpc_outstanding_n, 2);
    chk("dsp_ret_err", dpc_tracker_err, 0);
    pulse_reset();

    // Randomized traffic biased towards legal events.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 1000 == 500) pulse_reset();
      dcd_valid  = ($urandom_range(0, 99) < 60);
      dcd_id     = pick(S_IDLE);
      dcd_rd     = 5'($urandom_range(0, 7));
      dcd_rd_vld = 1'($urandom_range(0, 3) != 0);
      dcd_long   = 1'($urandom_range(0, 1));
      dsp_valid  = ($urandom_range(0, 99) < 50);
      dsp_id     = pick(S_DCD);
      ret_valid  = ($urandom_range(0, 99) < 40);
      ret_id     = pick(S_DSPTC);
      flush_req  = ($urandom_range(0, 99) < 4);
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      rdc        = 5'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    idle_in();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
